// File: rtl/cache_ctrl_wb.sv
// Direct-mapped, write-back, write-allocate cache controller driving external SRAM and SDRAM.
// Define CACHE_CTRL_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_ctrl_wb #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int TAG_SIZE    = 8,
   parameter int INDEX_SIZE  = 3,
   parameter int OFFSET_SIZE = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [ADDR_WIDTH-1:0]             Address_cpu,
   input  logic [DATA_WIDTH-1:0]             DOut_cpu,
   input  logic                              wr_rd_cpu,
   input  logic                              cs_cpu,
   output logic                              rdy_cpu,
   output logic [ADDR_WIDTH-1:0]             Address_sdram,
   output logic                              wr_rd_sdram,
   output logic                              mstrb_sdram,
   input  logic                              sdram_ack,
   output logic                              mux_sel,
   output logic                              demux_sel,
   output logic                              wen_sram,
   output logic [INDEX_SIZE+OFFSET_SIZE-1:0] address_sram
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [15:0]                       hit_count,
   output logic [15:0]                       miss_count
`endif
);

   localparam int ADDR_WIDTH_SRAM = INDEX_SIZE + OFFSET_SIZE;
   localparam int LINES           = 2 ** INDEX_SIZE;
   localparam logic [OFFSET_SIZE-1:0] WORD_ZERO = '0;
   localparam logic [OFFSET_SIZE-1:0] WORD_ONE  = {{(OFFSET_SIZE-1){1'b0}}, 1'b1};

   if (TAG_SIZE + INDEX_SIZE + OFFSET_SIZE != ADDR_WIDTH) begin : g_bad_fields
      $error("cache_ctrl_wb: TAG_SIZE+INDEX_SIZE+OFFSET_SIZE must equal ADDR_WIDTH");
   end

   typedef enum logic [2:0] {
      IDLE, LOOKUP, ACCESS, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT
   } state_t;

   state_t                     r_state;
   logic [LINES-1:0]           r_valid;
   logic [LINES-1:0]           r_dirty;
   logic [TAG_SIZE-1:0]        r_tag [LINES];
   logic [TAG_SIZE-1:0]        r_cap_tag;
   logic [INDEX_SIZE-1:0]      r_idx;
   logic [OFFSET_SIZE-1:0]     r_off;
   logic                       r_wr;
   logic [DATA_WIDTH-1:0]      r_data;
   logic [OFFSET_SIZE-1:0]     r_word;
   logic                       r_rdy;
   logic                       r_mstrb;
   logic                       r_wr_sdram;
   logic [ADDR_WIDTH-1:0]      r_addr_sdram;
   logic                       r_mux;
   logic                       r_demux;
   logic                       r_wen;
   logic [ADDR_WIDTH_SRAM-1:0] r_addr_sram;

   logic                       w_hit;
   logic                       w_victim_dirty;
   logic                       w_last;
   logic                       w_fill_ack;
   logic [OFFSET_SIZE-1:0]     w_word_nxt;
   logic                       w_unused_data;

   assign w_hit          = r_valid[r_idx] && (r_tag[r_idx] == r_cap_tag);
   assign w_victim_dirty = r_valid[r_idx] && r_dirty[r_idx];
   assign w_last         = &r_word;
   assign w_fill_ack     = (r_state == FILL_WAIT) && sdram_ack;
   assign w_word_nxt     = r_word + WORD_ONE;
   // Write data reaches the SRAM through the external mux; the captured copy is not consumed here.
   assign w_unused_data  = ^r_data;

   // Controller FSM with registered handshake, SDRAM and SRAM control outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_valid      <= '0;
         r_dirty      <= '0;
         r_cap_tag    <= '0;
         r_idx        <= '0;
         r_off        <= '0;
         r_wr         <= 1'b0;
         r_data       <= '0;
         r_word       <= '0;
         r_rdy        <= 1'b1;
         r_mstrb      <= 1'b0;
         r_wr_sdram   <= 1'b0;
         r_addr_sdram <= '0;
         r_mux        <= 1'b0;
         r_demux      <= 1'b0;
         r_wen        <= 1'b0;
         r_addr_sram  <= '0;
      end else begin
         r_mstrb <= 1'b0;
         r_wen   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cs_cpu) begin
                  {r_cap_tag, r_idx, r_off} <= Address_cpu;
                  r_data  <= DOut_cpu;
                  r_wr    <= wr_rd_cpu;
                  r_rdy   <= 1'b0;
                  r_state <= LOOKUP;
               end
            end
            LOOKUP: begin
               r_word <= WORD_ZERO;
               if (w_hit) begin
                  r_state     <= ACCESS;
                  r_addr_sram <= {r_idx, r_off};
                  r_wen       <= r_wr;
                  r_mux       <= 1'b0;
                  r_demux     <= 1'b0;
               end else if (w_victim_dirty) begin
                  r_state      <= WB_REQ;
                  r_mstrb      <= 1'b1;
                  r_wr_sdram   <= 1'b1;
                  r_addr_sdram <= {r_tag[r_idx], r_idx, WORD_ZERO};
                  r_addr_sram  <= {r_idx, WORD_ZERO};
                  r_demux      <= 1'b1;
               end else begin
                  r_valid[r_idx] <= 1'b0;
                  r_state        <= FILL_REQ;
                  r_mstrb        <= 1'b1;
                  r_wr_sdram     <= 1'b0;
                  r_addr_sdram   <= {r_cap_tag, r_idx, WORD_ZERO};
                  r_addr_sram    <= {r_idx, WORD_ZERO};
                  r_mux          <= 1'b1;
                  r_demux        <= 1'b0;
               end
            end
            ACCESS: begin
               if (r_wr) begin
                  r_dirty[r_idx] <= 1'b1;
               end
               r_rdy   <= 1'b1;
               r_state <= IDLE;
            end
            WB_REQ: begin
               r_state <= WB_WAIT;
            end
            WB_WAIT: begin
               if (sdram_ack && !w_last) begin
                  r_word       <= w_word_nxt;
                  r_state      <= WB_REQ;
                  r_mstrb      <= 1'b1;
                  r_addr_sdram <= {r_tag[r_idx], r_idx, w_word_nxt};
                  r_addr_sram  <= {r_idx, w_word_nxt};
               end else if (sdram_ack) begin
                  // victim is now in SDRAM; the line stays invalid until its refill completes
                  r_word         <= WORD_ZERO;
                  r_valid[r_idx] <= 1'b0;
                  r_state        <= FILL_REQ;
                  r_mstrb        <= 1'b1;
                  r_wr_sdram     <= 1'b0;
                  r_addr_sdram   <= {r_cap_tag, r_idx, WORD_ZERO};
                  r_addr_sram    <= {r_idx, WORD_ZERO};
                  r_mux          <= 1'b1;
                  r_demux        <= 1'b0;
               end
            end
            FILL_REQ: begin
               r_state <= FILL_WAIT;
            end
            FILL_WAIT: begin
               if (sdram_ack && !w_last) begin
                  r_word       <= w_word_nxt;
                  r_state      <= FILL_REQ;
                  r_mstrb      <= 1'b1;
                  r_addr_sdram <= {r_cap_tag, r_idx, w_word_nxt};
                  r_addr_sram  <= {r_idx, w_word_nxt};
               end else if (sdram_ack) begin
                  r_valid[r_idx] <= 1'b1;
                  r_dirty[r_idx] <= 1'b0;
                  r_state        <= ACCESS;
                  r_addr_sram    <= {r_idx, r_off};
                  r_wen          <= r_wr;
                  r_mux          <= 1'b0;
                  r_demux        <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_rdy   <= 1'b1;
            end
         endcase
      end
   end

   // Tag store, written when the last word of a line fill is acknowledged
   always_ff @(posedge clk) begin
      if (w_fill_ack && w_last) begin
         r_tag[r_idx] <= r_cap_tag;
      end
   end

   assign rdy_cpu       = r_rdy;
   assign Address_sdram = r_addr_sdram;
   assign wr_rd_sdram   = r_wr_sdram;
   assign mstrb_sdram   = r_mstrb;
   assign mux_sel       = r_mux;
   assign demux_sel     = r_demux;
   assign address_sram  = r_addr_sram;
   // Fill words are written in the acknowledge cycle itself, while SDRAM data is on the bus
   assign wen_sram      = r_wen | w_fill_ack;

`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] r_hit_cnt;
   logic [15:0] r_miss_cnt;

   // Saturating hit/miss counters, updated once per lookup
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hit_cnt  <= 16'h0000;
         r_miss_cnt <= 16'h0000;
      end else if (r_state == LOOKUP) begin
         if (w_hit) begin
            if (r_hit_cnt != 16'hFFFF) begin
               r_hit_cnt <= r_hit_cnt + 16'h0001;
            end
         end else if (r_miss_cnt != 16'hFFFF) begin
            r_miss_cnt <= r_miss_cnt + 16'h0001;
         end
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Randomized self-checking bench for cache_ctrl_wb against a line-level cache model.
// Honours CACHE_CTRL_STATS_EN to connect and check the statistics outputs.
module tb_cache_ctrl_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] Address_cpu;
   logic [7:0]  DOut_cpu;
   logic        wr_rd_cpu;
   logic        cs_cpu;
   logic        rdy_cpu;
   logic [15:0] Address_sdram;
   logic        wr_rd_sdram;
   logic        mstrb_sdram;
   logic        sdram_ack;
   logic        mux_sel;
   logic        demux_sel;
   logic        wen_sram;
   logic [7:0]  address_sram;
`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic       m_valid [8];
   logic       m_dirty [8];
   logic [7:0] m_tag   [8];
   int         m_hits;
   int         m_misses;

   always #5 clk = ~clk;

   cache_ctrl_wb dut (
      .clk           (clk),
      .rst           (rst),
      .Address_cpu   (Address_cpu),
      .DOut_cpu      (DOut_cpu),
      .wr_rd_cpu     (wr_rd_cpu),
      .cs_cpu        (cs_cpu),
      .rdy_cpu       (rdy_cpu),
      .Address_sdram (Address_sdram),
      .wr_rd_sdram   (wr_rd_sdram),
      .mstrb_sdram   (mstrb_sdram),
      .sdram_ack     (sdram_ack),
      .mux_sel       (mux_sel),
      .demux_sel     (demux_sel),
      .wen_sram      (wen_sram),
      .address_sram  (address_sram)
`ifdef CACHE_CTRL_STATS_EN
      ,
      .hit_count     (hit_count),
      .miss_count    (miss_count)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = 8'h00;
      end
      m_hits   = 0;
      m_misses = 0;
   endtask

   // SDRAM responder: acks each strobe after 1..3 cycles, sometimes with a stray ack in the strobe cycle
   initial begin
      int rsp_pend = 0;
      sdram_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         sdram_ack = 1'b0;
         if (!rst) begin
            rsp_pend = 0;
         end else if (rsp_pend > 0) begin
            rsp_pend--;
            if (rsp_pend == 0) sdram_ack = 1'b1;
         end else if (mstrb_sdram) begin
            rsp_pend  = $urandom_range(1, 3);
            sdram_ack = ($urandom_range(0, 3) == 0);
         end
      end
   end

   task automatic do_txn(input logic [15:0] a, input logic wr, input logic [7:0] d);
      logic [2:0]  idx;
      logic [7:0]  tg;
      logic [4:0]  off;
      logic        hit;
      logic [17:0] exp_req [$];
      logic [17:0] obs_req [$];
      logic [8:0]  exp_wen [$];
      logic [8:0]  obs_wen [$];
      int          busy;
      logic        inflight;
      logic [15:0] h_sd;
      logic [7:0]  h_sr;
      logic        h_wr;
      logic [7:0]  last_sr;
      logic        last_demux;
      idx = a[7:5];
      tg  = a[15:8];
      off = a[4:0];
      hit = m_valid[idx] && (m_tag[idx] == tg);
      if (hit) begin
         m_hits++;
      end else begin
         m_misses++;
         if (m_valid[idx] && m_dirty[idx])
            for (int w = 0; w < 32; w++) exp_req.push_back({1'b1, 1'b1, m_tag[idx], idx, 5'(w)});
         for (int w = 0; w < 32; w++) begin
            exp_req.push_back({1'b0, 1'b0, tg, idx, 5'(w)});
            exp_wen.push_back({1'b1, idx, 5'(w)});
         end
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         m_dirty[idx] = 1'b0;
      end
      if (wr) begin
         exp_wen.push_back({1'b0, idx, off});
         m_dirty[idx] = 1'b1;
      end

      @(negedge clk);
      check_val("rdy_before_req", 32'(rdy_cpu), 32'd1);
      Address_cpu = a;
      wr_rd_cpu   = wr;
      DOut_cpu    = d;
      cs_cpu      = 1'b1;
      @(negedge clk);
      Address_cpu = 16'($urandom);
      busy        = 0;
      inflight    = 1'b0;
      h_sd = 16'h0000; h_sr = 8'h00; h_wr = 1'b0; last_sr = 8'h00; last_demux = 1'b0;
      while (rdy_cpu !== 1'b1 && busy < 4000) begin
         busy++;
         if (mstrb_sdram) begin
            obs_req.push_back({wr_rd_sdram, demux_sel & wr_rd_sdram, Address_sdram});
            inflight = 1'b1;
            h_sd = Address_sdram;
            h_sr = address_sram;
            h_wr = wr_rd_sdram;
         end else if (inflight) begin
            check_val("hold_addr_sdram", 32'(Address_sdram), 32'(h_sd));
            check_val("hold_wr_rd_sdram", 32'(wr_rd_sdram), 32'(h_wr));
            check_val("hold_address_sram", 32'(address_sram), 32'(h_sr));
            if (sdram_ack) inflight = 1'b0;
         end
         if (wen_sram) obs_wen.push_back({mux_sel, address_sram});
         last_sr    = address_sram;
         last_demux = demux_sel;
         cs_cpu     = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      cs_cpu = 1'b0;
      check_val("txn_timeout", 32'(busy >= 4000), 32'd0);
      if (hit) check_val("hit_busy_cycles", 32'(busy), 32'd2);
      check_val("access_addr", 32'(last_sr), 32'({idx, off}));
      if (!wr) check_val("access_demux", 32'(last_demux), 32'd0);
      check_val("sdram_req_count", 32'(obs_req.size()), 32'(exp_req.size()));
      check_val("sram_wen_count", 32'(obs_wen.size()), 32'(exp_wen.size()));
      for (int i = 0; i < exp_req.size() && i < obs_req.size(); i++)
         check_val("sdram_req", 32'(obs_req[i]), 32'(exp_req[i]));
      for (int i = 0; i < exp_wen.size() && i < obs_wen.size(); i++)
         check_val("sram_wen", 32'(obs_wen[i]), 32'(exp_wen[i]));
   endtask

   initial begin
      int         acks;
      int         cyc;
      logic [7:0] t;
      rst         = 1'b0;
      cs_cpu      = 1'b0;
      Address_cpu = 16'h0000;
      DOut_cpu    = 8'h00;
      wr_rd_cpu   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_val("rst_rdy", 32'(rdy_cpu), 32'd1);
      check_val("rst_mstrb", 32'(mstrb_sdram), 32'd0);
      check_val("rst_wen", 32'(wen_sram), 32'd0);
      check_val("rst_addr_sdram", 32'(Address_sdram), 32'h0000);
      rst = 1'b1;
      @(negedge clk);
      check_val("post_rst_rdy", 32'(rdy_cpu), 32'd1);
      check_val("post_rst_addr_sdram", 32'(Address_sdram), 32'h0000);

      do_txn(16'h1234, 1'b0, 8'h00);
      do_txn(16'h1234, 1'b1, 8'hA5);
      do_txn(16'h5634, 1'b0, 8'h00);
`ifdef CACHE_CTRL_STATS_EN
      check_val("stats_miss", 32'(miss_count), 32'd2);
      check_val("stats_hit", 32'(hit_count), 32'd1);
`endif

      // Reset in the middle of a line fill
      @(negedge clk);
      Address_cpu = 16'h1234;
      wr_rd_cpu   = 1'b0;
      cs_cpu      = 1'b1;
      @(negedge clk);
      cs_cpu = 1'b0;
      acks   = 0;
      cyc    = 0;
      while (acks < 10 && cyc < 2000) begin
         if (sdram_ack && wen_sram) acks++;
         if (acks < 10) begin
            @(negedge clk);
            cyc++;
         end
      end
      check_val("mid_fill_acks", 32'(acks), 32'd10);
      rst = 1'b0;
      #1;
      check_val("mid_rst_rdy", 32'(rdy_cpu), 32'd1);
      check_val("mid_rst_mstrb", 32'(mstrb_sdram), 32'd0);
      check_val("mid_rst_wen", 32'(wen_sram), 32'd0);
      check_val("mid_rst_addr_sdram", 32'(Address_sdram), 32'h0000);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      do_txn(16'h1234, 1'b0, 8'h00);

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 2))
            0:       t = 8'h12;
            1:       t = 8'h56;
            default: t = 8'($urandom);
         endcase
         do_txn({t, 3'($urandom_range(0, 7)), 5'($urandom)}, 1'($urandom_range(0, 1)), 8'($urandom));
      end
`ifdef CACHE_CTRL_STATS_EN
      check_val("stats_hit_total", 32'(hit_count), 32'(m_hits));
      check_val("stats_miss_total", 32'(miss_count), 32'(m_misses));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cache_ctrl_wb.md
CACHE_CTRL_WB -- requirements
Module: cache_ctrl_wb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning CPU/SDRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data word width.
REQ-003 SHALL have parameters TAG_SIZE/INDEX_SIZE/OFFSET_SIZE, defaults 8/3/5, meaning address field widths; TAG_SIZE+INDEX_SIZE+OFFSET_SIZE SHALL equal ADDR_WIDTH, else elaboration error.
REQ-004 SHALL derive localparam ADDR_WIDTH_SRAM = INDEX_SIZE+OFFSET_SIZE and LINES = 2**INDEX_SIZE.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising edge); rst input 1 (asserted at 0).
REQ-006 Address_cpu input ADDR_WIDTH, CPU address; DOut_cpu input DATA_WIDTH, CPU write data; wr_rd_cpu input 1, 1=write 0=read; cs_cpu input 1, request strobe.
REQ-007 rdy_cpu output 1, controller idle/access complete.
REQ-008 Address_sdram output ADDR_WIDTH; wr_rd_sdram output 1 (1=write); mstrb_sdram output 1, word request pulse; sdram_ack input 1, word-complete pulse.
REQ-009 mux_sel output 1, SRAM write source (0=CPU, 1=SDRAM); demux_sel output 1, SRAM read sink (0=CPU, 1=SDRAM); wen_sram output 1, SRAM write enable; address_sram output ADDR_WIDTH_SRAM.

Function
REQ-010 SHALL implement direct-mapped, write-back, write-allocate cache with per-line valid, dirty, TAG_SIZE tag registers.
REQ-011 FSM states: IDLE, LOOKUP, ACCESS, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT.
REQ-012 IDLE: rdy_cpu=1; cs_cpu=1 captures Address_cpu, DOut_cpu, wr_rd_cpu, next state LOOKUP with rdy_cpu=0.
REQ-013 cs_cpu SHALL be ignored outside IDLE; sdram_ack SHALL be ignored outside WB_WAIT/FILL_WAIT.
REQ-014 LOOKUP (1 cycle): hit = valid[index] and tag[index]==captured tag; hit->ACCESS; miss with valid&dirty->WB_REQ; otherwise->FILL_REQ; word counter cleared.
REQ-015 ACCESS (1 cycle): address_sram={index,offset}; write: wen_sram=1, mux_sel=0, dirty[index]<=1; read: wen_sram=0, demux_sel=0; next IDLE.
REQ-016 Hit latency: rdy_cpu low exactly 2 cycles (LOOKUP, ACCESS).
REQ-017 WB_REQ (1 cycle): mstrb_sdram=1, wr_rd_sdram=1, Address_sdram={stored tag,index,word}, address_sram={index,word}, demux_sel=1; next WB_WAIT.
REQ-018 FILL_REQ (1 cycle): mstrb_sdram=1, wr_rd_sdram=0, Address_sdram={captured tag,index,word}; next FILL_WAIT.
REQ-019 Address_sdram, wr_rd_sdram, address_sram SHALL hold stable through *_WAIT until sdram_ack; ack in the mstrb cycle is ignored.
REQ-020 FILL_WAIT on sdram_ack: wen_sram=1, mux_sel=1, address_sram={index,word} for that cycle.
REQ-021 On ack, word<2**OFFSET_SIZE-1: word+1, back to *_REQ; last word: WB->FILL_REQ with word=0; FILL->set tag, valid=1, dirty=0, then ACCESS.
REQ-022 mstrb_sdram and wen_sram SHALL be single-cycle pulses; default 0 in all other states.

Reset
REQ-023 rst=0 SHALL asynchronously force: state IDLE, rdy_cpu=1, all other outputs 0, all valid/dirty bits 0, word counter 0.
REQ-024 Reset mid-WB/FILL SHALL abandon the burst; the line SHALL be invalid afterwards.

Configuration
REQ-025 Macro CACHE_CTRL_STATS_EN: defined adds outputs hit_count, miss_count (16 bits each), incremented in LOOKUP, saturating at 0xFFFF, cleared by reset; undefined the ports and logic SHALL not exist.

Verification
REQ-026 Reset release -> rdy_cpu=1, mstrb_sdram=0, wen_sram=0, Address_sdram=0x0000.
REQ-027 Cold read 0x1234 -> 32 mstrb read pulses Address_sdram 0x1220..0x123F, 32 wen_sram pulses address_sram 0x20..0x3F, then ACCESS address_sram=0x34, rdy_cpu=1.
REQ-028 Write 0xA5 to 0x1234 after fill -> rdy_cpu low 2 cycles, wen_sram=1, mux_sel=0, address_sram=0x34, no mstrb.
REQ-029 Then read 0x5634 -> 32 write pulses 0x1220..0x123F (demux_sel=1) followed by 32 read pulses 0x5620..0x563F.
REQ-030 rst=0 after 10th fill ack -> rdy_cpu=1 immediately; re-read 0x1234 restarts fill at 0x1220.
REQ-031 With CACHE_CTRL_STATS_EN: sequence REQ-027..029 -> miss_count=2, hit_count=1.
